// File: rtl/lj_audio_rx.sv
// lj_audio_rx: left-justified serial audio receiver (ASCLK/ASDATA/ALRCLK).
// Oversamples the serial link in the AMCLK domain and presents parallel
// left/right words with one-cycle per-channel valid strobes.
// Optional lock watchdog: define LJ_AUDIO_RX_TIMEOUT_EN.
`timescale 1ns/1ps

module lj_audio_rx #(
    parameter int unsigned DATA_WIDTH     = 24,
    parameter int unsigned SLOT_MAX       = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  AMCLK_i,
    input  logic                  ARST,
    input  logic                  ASCLK_i,
    input  logic                  ASDATA_i,
    input  logic                  ALRCLK_i,
    output logic [DATA_WIDTH-1:0] APDATA_LEFT_o,
    output logic [DATA_WIDTH-1:0] APDATA_RIGHT_o,
    output logic [1:0]            APDATA_VALID_o,
    output logic                  FRAME_ERR_o,
    output logic                  LOCKED_o
);

    localparam int unsigned CNT_W = $clog2(SLOT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SLOT_MAX);

    localparam logic [0:0] S_HUNT = 1'b0;
    localparam logic [0:0] S_RECV = 1'b1;

    // Shift register needs at least two bits; counter must be able to reach a full word.
    if (DATA_WIDTH < 2 || SLOT_MAX < DATA_WIDTH || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("lj_audio_rx: unsupported parameter set");
    end

    // Synchronised inputs and edge detector
    logic sclk_s1, sclk_s2, sclk_d;
    logic lr_s1, lr_s2;
    logic dat_s1, dat_s2;
    logic rise;

    // Registered state
    logic [0:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [1:0]            pend;
    logic                  lr_prev;
    logic                  lr_seen;

    // Next-state values
    logic [0:0]            state_nxt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic [DATA_WIDTH-1:0] shreg_nxt;
    logic [1:0]            pend_nxt;
    logic                  lr_prev_nxt;
    logic                  lr_seen_nxt;
    logic [DATA_WIDTH-1:0] left_nxt;
    logic [DATA_WIDTH-1:0] right_nxt;
    logic [1:0]            valid_nxt;
    logic                  err_nxt;
    logic                  locked_nxt;
    logic                  boundary;
    logic                  bit_loaded;

`ifdef LJ_AUDIO_RX_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
    logic [WD_W-1:0] wdog;
    logic [WD_W-1:0] wdog_nxt;
`endif

    // Two-flop synchronisers plus a third ASCLK flop for rise detection
    always_ff @(posedge AMCLK_i or posedge ARST) begin
        if (ARST) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_d  <= 1'b0;
            lr_s1   <= 1'b0;
            lr_s2   <= 1'b0;
            dat_s1  <= 1'b0;
            dat_s2  <= 1'b0;
        end else begin
            sclk_s1 <= ASCLK_i;
            sclk_s2 <= sclk_s1;
            sclk_d  <= sclk_s2;
            lr_s1   <= ALRCLK_i;
            lr_s2   <= lr_s1;
            dat_s1  <= ASDATA_i;
            dat_s2  <= dat_s1;
        end
    end

    assign rise = sclk_s2 & ~sclk_d;

    // State and output registers
    always_ff @(posedge AMCLK_i or posedge ARST) begin
        if (ARST) begin
            state          <= S_HUNT;
            cnt            <= '0;
            shreg          <= '0;
            pend           <= 2'b00;
            lr_prev        <= 1'b0;
            lr_seen        <= 1'b0;
            APDATA_LEFT_o  <= '0;
            APDATA_RIGHT_o <= '0;
            APDATA_VALID_o <= 2'b00;
            FRAME_ERR_o    <= 1'b0;
            LOCKED_o       <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            shreg          <= shreg_nxt;
            pend           <= pend_nxt;
            lr_prev        <= lr_prev_nxt;
            lr_seen        <= lr_seen_nxt;
            APDATA_LEFT_o  <= left_nxt;
            APDATA_RIGHT_o <= right_nxt;
            APDATA_VALID_o <= valid_nxt;
            FRAME_ERR_o    <= err_nxt;
            LOCKED_o       <= locked_nxt;
        end
    end

`ifdef LJ_AUDIO_RX_TIMEOUT_EN
    // Watchdog: AMCLK cycles since the last ASCLK rise, saturating
    always_ff @(posedge AMCLK_i or posedge ARST) begin
        if (ARST) begin
            wdog <= '0;
        end else begin
            wdog <= wdog_nxt;
        end
    end
`endif

    // Slot tracking, deserialisation and output selection
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        shreg_nxt   = shreg;
        pend_nxt    = 2'b00;
        lr_prev_nxt = lr_prev;
        lr_seen_nxt = lr_seen;
        left_nxt    = APDATA_LEFT_o;
        right_nxt   = APDATA_RIGHT_o;
        valid_nxt   = pend;
        err_nxt     = 1'b0;
        boundary    = 1'b0;
        bit_loaded  = 1'b0;

        // A completed word is published one cycle after its last bit lands
        if (pend[1]) begin
            left_nxt = shreg;
        end
        if (pend[0]) begin
            right_nxt = shreg;
        end

        if (rise) begin
            lr_prev_nxt = lr_s2;
            lr_seen_nxt = 1'b1;
            // The very first sample after reset has no predecessor to compare to
            boundary    = lr_seen && (lr_s2 != lr_prev);

            if (boundary) begin
                if (state == S_RECV && cnt < CNT_FULL) begin
                    err_nxt = 1'b1;
                end
                state_nxt  = S_RECV;
                shreg_nxt  = DATA_WIDTH'(dat_s2);
                cnt_nxt    = CNT_W'(1);
                bit_loaded = 1'b1;
            end else if (state == S_RECV) begin
                if (cnt < CNT_FULL) begin
                    shreg_nxt  = {shreg[DATA_WIDTH-2:0], dat_s2};
                    cnt_nxt    = cnt + CNT_W'(1);
                    bit_loaded = 1'b1;
                end else if (cnt < CNT_SAT) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            if (bit_loaded && cnt_nxt == CNT_FULL) begin
                pend_nxt = lr_s2 ? 2'b10 : 2'b01;
            end
        end

`ifdef LJ_AUDIO_RX_TIMEOUT_EN
        wdog_nxt = wdog;
        if (rise) begin
            wdog_nxt = '0;
        end else if (wdog != WD_MAX) begin
            wdog_nxt = wdog + WD_W'(1);
        end
        // A silent bit clock drops lock and discards the partial word quietly
        if (!rise && state == S_RECV && wdog_nxt == WD_MAX) begin
            state_nxt = S_HUNT;
            cnt_nxt   = '0;
            shreg_nxt = '0;
        end
`endif

        locked_nxt = (state_nxt == S_RECV);
    end

endmodule

// File: tb/tb_lj_audio_rx.sv
// Testbench for lj_audio_rx: drives left-justified serial slots at
// ASCLK = AMCLK/8 and checks received words against a slot-level model.
`timescale 1ns/1ps

module tb_lj_audio_rx;

    localparam int unsigned DW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          asclk, asdata, alrclk;
    logic [DW-1:0] left, right;
    logic [1:0]    valid;
    logic          ferr, locked;

    always #5 clk = ~clk;

    lj_audio_rx #(
        .DATA_WIDTH    (24),
        .SLOT_MAX      (32),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .AMCLK_i       (clk),
        .ARST          (rst),
        .ASCLK_i       (asclk),
        .ASDATA_i      (asdata),
        .ALRCLK_i      (alrclk),
        .APDATA_LEFT_o (left),
        .APDATA_RIGHT_o(right),
        .APDATA_VALID_o(valid),
        .FRAME_ERR_o   (ferr),
        .LOCKED_o      (locked)
    );

    typedef struct {
        bit          lr;
        int          width;
        logic [31:0] word;
    } slot_t;

    int checks   = 0;
    int failures = 0;

    time           last_rise;
    logic [DW-1:0] l_log[$], r_log[$];
    time           st_time[$], err_time[$];
    int            both_cnt;
    logic [DW-1:0] exp_l[$], exp_r[$];
    int            exp_err;
    slot_t         slots[$];
    time           lsb_rise[$], first_rise[$];

    // Observe outputs on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (valid[1]) begin
                l_log.push_back(left);
                st_time.push_back($time);
            end
            if (valid[0]) begin
                r_log.push_back(right);
                if (!valid[1]) st_time.push_back($time);
            end
            if (valid == 2'b11) both_cnt++;
            if (ferr) err_time.push_back($time);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout sim did not finish");
        $fatal(1, "timeout");
    end

    task automatic clear_logs();
        l_log.delete(); r_log.delete(); st_time.delete(); err_time.delete();
        exp_l.delete(); exp_r.delete(); slots.delete();
        lsb_rise.delete(); first_rise.delete();
        both_cnt = 0;
        exp_err  = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; asclk = 1'b0; asdata = 1'b0; alrclk = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_logs();
        @(negedge clk);
    endtask

    // One ASCLK period: data/word-select change on the falling edge
    task automatic send_bit(input bit lr, input bit d);
        asclk = 1'b0; alrclk = lr; asdata = d;
        #40;
        asclk = 1'b1;
        last_rise = $time;
        #40;
    endtask

    // Slot word is left-justified in 32 bits; the first `width` bits go out
    task automatic send_slot(input slot_t s, input bit mark);
        for (int b = 0; b < s.width; b++) begin
            send_bit(s.lr, s.word[31-b]);
            if (b == 0) first_rise.push_back(last_rise);
            if (mark && b == DW - 1) lsb_rise.push_back(last_rise);
        end
    endtask

    // Slot-level model: slot 0 precedes the first boundary and is never
    // reported; later slots report their top DW bits if long enough, and a
    // short slot raises one error when the next slot begins.
    task automatic run_slots();
        for (int i = 0; i < slots.size(); i++) begin
            bit rep;
            rep = (i > 0) && (slots[i].width >= DW);
            if (rep) begin
                if (slots[i].lr) exp_l.push_back(slots[i].word[31:8]);
                else             exp_r.push_back(slots[i].word[31:8]);
            end
            if (i > 0 && slots[i].width < DW && i + 1 < slots.size()) exp_err++;
            send_slot(slots[i], rep);
        end
        repeat (8) @(negedge clk);
    endtask

    function automatic slot_t mk(input bit lr, input int width, input logic [31:0] word);
        slot_t s;
        s.lr = lr; s.width = width; s.word = word;
        return s;
    endfunction

    task automatic test_reset();
        rst = 1'b1; asclk = 1'b0; asdata = 1'b0; alrclk = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({left, right, valid, ferr, locked} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got L=%h R=%h V=%b E=%b K=%b exp all 0", left, right, valid, ferr, locked);
        end
        rst = 1'b0;
    endtask

    task automatic test_stereo();
        do_reset();
        slots.push_back(mk(1'b1, 10, $urandom));
        slots.push_back(mk(1'b0, 32, {24'hABCDEF, 8'h5A}));
        slots.push_back(mk(1'b1, 32, {24'h123456, 8'hC3}));
        slots.push_back(mk(1'b0, 32, {24'hABCDEF, 8'h0F}));
        run_slots();
        checks++;
        if (l_log.size() !== exp_l.size() || r_log.size() !== exp_r.size()) begin
            failures++;
            $display("FAIL stereo_counts got l=%0d r=%0d exp l=%0d r=%0d", l_log.size(), r_log.size(), exp_l.size(), exp_r.size());
        end
        for (int i = 0; i < l_log.size() && i < exp_l.size(); i++) begin
            checks++;
            if (l_log[i] !== exp_l[i]) begin
                failures++; $display("FAIL stereo_left[%0d] got=%h exp=%h", i, l_log[i], exp_l[i]);
            end
        end
        for (int i = 0; i < r_log.size() && i < exp_r.size(); i++) begin
            checks++;
            if (r_log[i] !== exp_r[i]) begin
                failures++; $display("FAIL stereo_right[%0d] got=%h exp=%h", i, r_log[i], exp_r[i]);
            end
        end
        checks++;
        if (l_log.size() == 0 || l_log[0] !== 24'h123456) begin
            failures++; $display("FAIL stereo_first_left got_count=%0d exp=123456", l_log.size());
        end
        checks++;
        if (st_time.size() !== lsb_rise.size()) begin
            failures++; $display("FAIL stereo_strobe_count got=%0d exp=%0d", st_time.size(), lsb_rise.size());
        end
        for (int i = 0; i < st_time.size() && i < lsb_rise.size(); i++) begin
            checks++;
            if (st_time[i] - lsb_rise[i] !== time'(40)) begin
                failures++; $display("FAIL stereo_latency[%0d] got=%0t exp=40 ns", i, st_time[i] - lsb_rise[i]);
            end
        end
        checks++;
        if (err_time.size() !== 0 || both_cnt !== 0) begin
            failures++; $display("FAIL stereo_err_both got err=%0d both=%0d exp 0 0", err_time.size(), both_cnt);
        end
    endtask

    task automatic test_exact_fit();
        do_reset();
        slots.push_back(mk(1'b1, 5, $urandom));
        for (int i = 0; i < 8; i++) begin
            slots.push_back(mk(i[0] ? 1'b1 : 1'b0, 24, i[1] ? 32'h7FFFFF00 : 32'h80000000));
        end
        run_slots();
        checks++;
        if (l_log.size() !== exp_l.size() || r_log.size() !== exp_r.size()) begin
            failures++;
            $display("FAIL fit_counts got l=%0d r=%0d exp l=%0d r=%0d", l_log.size(), r_log.size(), exp_l.size(), exp_r.size());
        end
        for (int i = 0; i < l_log.size() && i < exp_l.size(); i++) begin
            checks++;
            if (l_log[i] !== exp_l[i]) begin
                failures++; $display("FAIL fit_left[%0d] got=%h exp=%h", i, l_log[i], exp_l[i]);
            end
        end
        for (int i = 0; i < r_log.size() && i < exp_r.size(); i++) begin
            checks++;
            if (r_log[i] !== exp_r[i]) begin
                failures++; $display("FAIL fit_right[%0d] got=%h exp=%h", i, r_log[i], exp_r[i]);
            end
        end
        checks++;
        if (err_time.size() !== 0) begin
            failures++; $display("FAIL fit_frame_err got=%0d exp=0", err_time.size());
        end
    endtask

    task automatic test_truncated();
        logic [31:0] r1, l1, l2;
        r1 = $urandom; l1 = $urandom; l2 = $urandom;
        do_reset();
        slots.push_back(mk(1'b1, 6, $urandom));
        slots.push_back(mk(1'b0, 32, r1));
        slots.push_back(mk(1'b1, 32, l1));
        slots.push_back(mk(1'b0, 16, $urandom));
        slots.push_back(mk(1'b1, 32, l2));
        run_slots();
        checks++;
        if (err_time.size() !== exp_err) begin
            failures++; $display("FAIL trunc_err_count got=%0d exp=%0d", err_time.size(), exp_err);
        end
        checks++;
        if (err_time.size() < 1 || err_time[0] - first_rise[4] !== time'(30)) begin
            failures++; $display("FAIL trunc_err_timing got_count=%0d exp pulse 30 ns after left MSB rise", err_time.size());
        end
        checks++;
        if (right !== r1[31:8]) begin
            failures++; $display("FAIL trunc_right_hold got=%h exp=%h", right, r1[31:8]);
        end
        checks++;
        if (left !== l2[31:8] || l_log.size() !== exp_l.size()) begin
            failures++; $display("FAIL trunc_next_left got=%h n=%0d exp=%h n=%0d", left, l_log.size(), l2[31:8], exp_l.size());
        end
        checks++;
        if (r_log.size() !== 1) begin
            failures++; $display("FAIL trunc_right_strobes got=%0d exp=1", r_log.size());
        end
    endtask

    task automatic test_reset_midword();
        logic [31:0] w, r2, l3;
        w = $urandom; r2 = $urandom; l3 = $urandom;
        do_reset();
        slots.push_back(mk(1'b0, 8, $urandom));
        slots.push_back(mk(1'b1, 32, $urandom));
        slots.push_back(mk(1'b0, 32, $urandom));
        run_slots();
        for (int b = 0; b < 12; b++) send_bit(1'b1, w[31-b]);
        rst = 1'b1;
        #1;
        checks++;
        if ({left, right, valid, ferr, locked} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs got L=%h R=%h V=%b E=%b K=%b exp all 0", left, right, valid, ferr, locked);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_logs();
        slots.push_back(mk(1'b1, 20, w << 12));
        slots.push_back(mk(1'b0, 32, r2));
        slots.push_back(mk(1'b1, 32, l3));
        run_slots();
        checks++;
        if (l_log.size() !== 1 || r_log.size() !== 1 || l_log[0] !== l3[31:8] || r_log[0] !== r2[31:8]) begin
            failures++;
            $display("FAIL midreset_relock got l=%0d r=%0d exp one strobe each L=%h R=%h", l_log.size(), r_log.size(), l3[31:8], r2[31:8]);
        end
        checks++;
        if (locked !== 1'b1 || err_time.size() !== 0) begin
            failures++; $display("FAIL midreset_locked got K=%b err=%0d exp 1 0", locked, err_time.size());
        end
    endtask

    task automatic test_stall();
        logic [31:0]   w, l1, r1, l2, r2;
        logic [DW-1:0] hold_l, hold_r;
        int            fall_cyc;
        int            unlocked;
        w = $urandom; l1 = $urandom; r1 = $urandom; l2 = $urandom; r2 = $urandom;
        do_reset();
        slots.push_back(mk(1'b1, 4, $urandom));
        slots.push_back(mk(1'b0, 32, r1));
        slots.push_back(mk(1'b1, 32, l1));
        run_slots();
        hold_l = left; hold_r = right;
        clear_logs();
        for (int b = 0; b < 10; b++) send_bit(1'b0, w[31-b]);
        fall_cyc = -1;
        unlocked = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!locked) begin
                unlocked++;
                if (fall_cyc < 0) fall_cyc = c + 5;
            end
        end
`ifdef LJ_AUDIO_RX_TIMEOUT_EN
        checks++;
        if (fall_cyc < 64 || fall_cyc > 70) begin
            failures++; $display("FAIL stall_timeout_cycle got=%0d exp 64..70 cycles after last edge", fall_cyc);
        end
        checks++;
        if (left !== hold_l || right !== hold_r || ferr !== 1'b0 || err_time.size() !== 0) begin
            failures++; $display("FAIL stall_hold got L=%h R=%h err=%0d exp L=%h R=%h err=0", left, right, err_time.size(), hold_l, hold_r);
        end
        clear_logs();
        slots.push_back(mk(1'b0, 22, w << 10));
        slots.push_back(mk(1'b1, 32, l2));
        slots.push_back(mk(1'b0, 32, r2));
        run_slots();
        checks++;
        if (l_log.size() !== 1 || r_log.size() !== 1 || l_log[0] !== exp_l[0] || r_log[0] !== exp_r[0]) begin
            failures++; $display("FAIL stall_relock got l=%0d r=%0d exp L=%h R=%h", l_log.size(), r_log.size(), l2[31:8], r2[31:8]);
        end
        checks++;
        if (locked !== 1'b1) begin
            failures++; $display("FAIL stall_relocked got=%b exp=1", locked);
        end
`else
        checks++;
        if (unlocked !== 0) begin
            failures++; $display("FAIL stall_lock_kept got unlocked_cycles=%0d exp=0", unlocked);
        end
        exp_r.push_back(w[31:8]);
        for (int b = 10; b < 32; b++) send_bit(1'b0, w[31-b]);
        repeat (8) @(negedge clk);
        checks++;
        if (r_log.size() !== 1 || r_log[0] !== exp_r[0] || l_log.size() !== 0) begin
            failures++; $display("FAIL stall_resume_word got r=%0d l=%0d exp one right strobe %h", r_log.size(), l_log.size(), exp_r[0]);
        end
        checks++;
        if (left !== hold_l || err_time.size() !== 0) begin
            failures++; $display("FAIL stall_left_hold got=%h err=%0d exp=%h err=0", left, err_time.size(), hold_l);
        end
`endif
    endtask

    task automatic test_random();
        bit lr;
        do_reset();
        lr = 1'($urandom);
        slots.push_back(mk(lr, $urandom_range(1, 32), $urandom));
        for (int i = 0; i < 30; i++) begin
            lr = ~lr;
            slots.push_back(mk(lr, (i == 29) ? $urandom_range(24, 32) : $urandom_range(18, 32), $urandom));
        end
        run_slots();
        checks++;
        if (l_log.size() !== exp_l.size() || r_log.size() !== exp_r.size()) begin
            failures++;
            $display("FAIL rand_counts got l=%0d r=%0d exp l=%0d r=%0d", l_log.size(), r_log.size(), exp_l.size(), exp_r.size());
        end
        for (int i = 0; i < l_log.size() && i < exp_l.size(); i++) begin
            checks++;
            if (l_log[i] !== exp_l[i]) begin
                failures++; $display("FAIL rand_left[%0d] got=%h exp=%h", i, l_log[i], exp_l[i]);
            end
        end
        for (int i = 0; i < r_log.size() && i < exp_r.size(); i++) begin
            checks++;
            if (r_log[i] !== exp_r[i]) begin
                failures++; $display("FAIL rand_right[%0d] got=%h exp=%h", i, r_log[i], exp_r[i]);
            end
        end
        checks++;
        if (err_time.size() !== exp_err || both_cnt !== 0) begin
            failures++; $display("FAIL rand_errors got err=%0d both=%0d exp err=%0d both=0", err_time.size(), both_cnt, exp_err);
        end
    endtask

    initial begin
        test_reset();
        test_stereo();
        test_exact_fit();
        test_truncated();
        test_reset_midword();
        test_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
